// File: rtl/LSUFuncts.sv
// Load/store operation encoding and decode helpers for the LSU.
package LSUFuncts;

    typedef enum logic [2:0] {LB, LH, LW, LBU, LHU, SB, SH, SW} Type;

    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} Size;

    function automatic logic is_store(Type f);
        return f inside {SB, SH, SW};
    endfunction

    function automatic logic is_unsigned(Type f);
        return f inside {LBU, LHU};
    endfunction

    function automatic Size access_size(Type f);
        case (f)
            LB, LBU, SB: return SIZE_BYTE;
            LH, LHU, SH: return SIZE_HALF;
            default:     return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/RV32Consts.sv
// RV32 integer datapath constants shared across the core.
package RV32Consts;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] IntReg;

endpackage

// File: rtl/load_store_unit_pkg.sv
// LSU-local types: FSM states, bus command payload and alignment helpers.
package load_store_unit_pkg;

    import LSUFuncts::*;

    localparam int unsigned BUS_W = 32;
    localparam int unsigned BE_W  = 4;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_e;

    typedef struct packed {
        logic             we;
        logic [BUS_W-1:0] addr;
        logic [BUS_W-1:0] wdata;
        logic [BE_W-1:0]  be;
    } mem_cmd_t;

    function automatic logic is_misaligned(Type f, logic [1:0] off);
        case (access_size(f))
            SIZE_HALF: return off[0];
            SIZE_WORD: return off != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] align_offset(Type f, logic [1:0] off);
        case (access_size(f))
            SIZE_HALF: return {off[1], 1'b0};
            SIZE_WORD: return 2'b00;
            default:   return off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store replication/byte enables and
// load lane extraction with sign or zero extension.
module lsu_lane_align
    import RV32Consts::*;
    import LSUFuncts::*;
(
    input  Type        st_funct,
    input  logic [1:0] st_offset,
    input  IntReg      st_data,
    output IntReg      wdata_c,
    output logic [3:0] be_c,
    input  Type        ld_funct,
    input  logic [1:0] ld_offset,
    input  IntReg      ld_word,
    output IntReg      ld_data_c
);

    IntReg shifted_c;

    // Store data is replicated across lanes so the bus only needs byte enables.
    always_comb begin
        wdata_c = '0;
        be_c    = 4'b1111;
        if (is_store(st_funct)) begin
            case (access_size(st_funct))
                SIZE_BYTE: begin
                    wdata_c = {4{st_data[7:0]}};
                    be_c    = 4'b0001 << st_offset;
                end
                SIZE_HALF: begin
                    wdata_c = {2{st_data[15:0]}};
                    be_c    = st_offset[1] ? 4'b1100 : 4'b0011;
                end
                default: wdata_c = st_data;
            endcase
        end
    end

    always_comb begin
        shifted_c = ld_word >> {ld_offset, 3'b000};
        ld_data_c = shifted_c;
        case (access_size(ld_funct))
            SIZE_BYTE: ld_data_c = is_unsigned(ld_funct) ? IntReg'(shifted_c[7:0])
                                 : {{(XLEN-8){shifted_c[7]}}, shifted_c[7:0]};
            SIZE_HALF: ld_data_c = is_unsigned(ld_funct) ? IntReg'(shifted_c[15:0])
                                 : {{(XLEN-16){shifted_c[15]}}, shifted_c[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: one data-bus transaction per request, with
// timeout faults. LSU_MISALIGN_TRAP_EN selects trapping vs aligning misaligned ops.
module load_store_unit
    import RV32Consts::*;
    import LSUFuncts::*;
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  Type         funct,
    input  IntReg       addr,
    input  IntReg       wdata,
    output logic        stall,
    output logic        resp_valid,
    output IntReg       resp_rdata,
    output logic        resp_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    Type              lat_funct, lat_funct_n;
    logic [1:0]       lat_offset, lat_offset_n;
    mem_cmd_t         cmd, cmd_n;
    IntReg            resp_rdata_n;
    logic             resp_fault_n;
    logic             req_ready_n, stall_n, resp_valid_n, mem_req_n;

    logic             trap_c;
    logic             timeout_c;
    logic [1:0]       offset_c;
    IntReg            wdata_c, ld_data_c;
    logic [3:0]       be_c;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_c   = is_misaligned(funct, addr[1:0]);
    assign offset_c = addr[1:0];
`else
    assign trap_c   = 1'b0;
    assign offset_c = align_offset(funct, addr[1:0]);
`endif

    lsu_lane_align u_lane_align (
        .st_funct  (funct),
        .st_offset (offset_c),
        .st_data   (wdata),
        .wdata_c   (wdata_c),
        .be_c      (be_c),
        .ld_funct  (lat_funct),
        .ld_offset (lat_offset),
        .ld_word   (mem_rdata),
        .ld_data_c (ld_data_c)
    );

    assign timeout_c = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        lat_funct_n  = lat_funct;
        lat_offset_n = lat_offset;
        cmd_n        = cmd;
        resp_rdata_n = resp_rdata;
        resp_fault_n = resp_fault;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    lat_funct_n  = funct;
                    lat_offset_n = offset_c;
                    cmd_n.we     = is_store(funct);
                    cmd_n.addr   = {addr[XLEN-1:2], 2'b00};
                    cmd_n.wdata  = wdata_c;
                    cmd_n.be     = be_c;
                    cnt_n        = '0;
                    if (trap_c) begin
                        state_n      = S_DONE;
                        resp_rdata_n = '0;
                        resp_fault_n = 1'b1;
                    end else begin
                        state_n = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_n = cnt + CNT_W'(1);
                if (mem_gnt && is_store(lat_funct)) begin
                    state_n      = S_DONE;
                    resp_rdata_n = '0;
                    resp_fault_n = 1'b0;
                end else if (timeout_c) begin
                    state_n      = S_DONE;
                    resp_rdata_n = '0;
                    resp_fault_n = 1'b1;
                end else if (mem_gnt) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_n = cnt + CNT_W'(1);
                // Data arriving on the final allowed cycle still completes cleanly.
                if (mem_rvalid) begin
                    state_n      = S_DONE;
                    resp_rdata_n = ld_data_c;
                    resp_fault_n = 1'b0;
                end else if (timeout_c) begin
                    state_n      = S_DONE;
                    resp_rdata_n = '0;
                    resp_fault_n = 1'b1;
                end
            end
            S_DONE: state_n = S_IDLE;
        endcase
        req_ready_n  = (state_n == S_IDLE);
        stall_n      = (state_n != S_IDLE);
        resp_valid_n = (state_n == S_DONE);
        mem_req_n    = (state_n == S_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            lat_funct  <= LB;
            lat_offset <= '0;
            cmd        <= '0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
            req_ready  <= 1'b1;
            stall      <= 1'b0;
            resp_valid <= 1'b0;
            mem_req    <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            lat_funct  <= lat_funct_n;
            lat_offset <= lat_offset_n;
            cmd        <= cmd_n;
            resp_rdata <= resp_rdata_n;
            resp_fault <= resp_fault_n;
            req_ready  <= req_ready_n;
            stall      <= stall_n;
            resp_valid <= resp_valid_n;
            mem_req    <= mem_req_n;
        end
    end

    assign mem_we    = cmd.we;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;
    assign mem_be    = cmd.be;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model derives the
// expected per-cycle outputs, and a negedge process compares the DUT against them.
module tb_load_store_unit;

    import LSUFuncts::*;

    localparam int TMO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    Type         funct;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .funct      (funct),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int req_count;

    logic        chk_en = 1'b0;
    logic        exp_ready, exp_stall, exp_rv, exp_req, exp_we, exp_fault;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_be;
    logic        snap_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic bit model_misaligned(Type f, logic [31:0] a);
        int unsigned off = a % 4;
        if (f inside {LH, LHU, SH}) return (off % 2) != 0;
        if (f inside {LW, SW}) return off != 0;
        return 1'b0;
    endfunction

    function automatic int unsigned model_offset(Type f, logic [31:0] a);
        int unsigned off = a % 4;
        if (f inside {LH, LHU, SH}) off = off & 2;
        if (f inside {LW, SW}) off = 0;
        return off;
    endfunction

    function automatic logic [3:0] model_be(Type f, logic [31:0] a);
        int unsigned off = model_offset(f, a);
        if (f == SB) return 4'(1 << off);
        if (f == SH) return (off == 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(Type f, logic [31:0] wd);
        if (f == SB) return (wd % 256) * 32'h0101_0101;
        if (f == SH) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(Type f, logic [31:0] a, logic [31:0] w);
        int unsigned off = model_offset(f, a);
        logic [31:0] v = w >> (8 * off);
        if (f inside {LB, LBU}) begin
            v = v % 256;
            if (f == LB && v >= 128) v = v | 32'hFFFF_FF00;
        end else if (f inside {LH, LHU}) begin
            v = v % 65536;
            if (f == LH && v >= 32768) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic set_idle_exp();
        exp_ready = 1'b1;
        exp_stall = 1'b0;
        exp_rv    = 1'b0;
        exp_req   = 1'b0;
    endtask

    // g: cycles of bus stall before grant; r: cycles between grant+1 and rvalid.
    task automatic run(input Type f, input logic [31:0] a, input logic [31:0] wd,
                       input int g, input int r, input logic [31:0] rd);
        bit st;
        bit trap;
        bit fault;
        int gc;
        int rc;
        int done;
        int req_end;
        st      = f inside {SB, SH, SW};
        trap    = TRAP && model_misaligned(f, a);
        gc      = 1 + g;
        rc      = gc + 1 + r;
        req_end = (gc < TMO) ? gc : TMO;
        if (trap) begin
            done = 1; fault = 1'b1; req_end = 0;
        end else if (st) begin
            if (gc <= TMO) begin done = gc + 1; fault = 1'b0; end
            else begin done = TMO + 1; fault = 1'b1; end
        end else begin
            if (gc < TMO && rc <= TMO) begin done = rc + 1; fault = 1'b0; end
            else begin done = TMO + 1; fault = 1'b1; end
        end
        req_count = 0;
        funct     = f;
        addr      = a;
        wdata     = wd;
        req_valid = 1'b1;
        set_idle_exp();
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= done + 1; k++) begin
            req_count += int'(mem_req);
            if (k == 1) begin
                snap_addr = mem_addr; snap_wdata = mem_wdata;
                snap_be = mem_be; snap_we = mem_we;
            end
            exp_stall = (k <= done);
            exp_ready = !exp_stall;
            exp_rv    = (k == done);
            exp_req   = !trap && (k <= req_end);
            exp_we    = st;
            exp_addr  = {a[31:2], 2'b00};
            exp_be    = model_be(f, a);
            exp_wdata = model_wdata(f, wd);
            if (k == done) begin
                exp_fault = fault;
                exp_rdata = (fault || st) ? 32'h0 : model_load(f, a, rd);
            end
            // Stray grant in DONE and stray rvalid in IDLE must be ignored.
            mem_gnt    = (k == gc) || (k == done);
            mem_rvalid = (!st && k == rc) || (k == done + 1);
            mem_rdata  = (k == rc) ? rd : 32'h0BAD_0BAD;
            @(posedge clk); #1;
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        set_idle_exp();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"},      32'(req_ready),  32'h1);
        check({tag, "_stall"},      32'(stall),      32'h0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
        check({tag, "_resp_rdata"}, resp_rdata,      32'h0);
        check({tag, "_resp_fault"}, 32'(resp_fault), 32'h0);
        check({tag, "_mem_req"},    32'(mem_req),    32'h0);
        check({tag, "_mem_we"},     32'(mem_we),     32'h0);
        check({tag, "_mem_addr"},   mem_addr,        32'h0);
        check({tag, "_mem_wdata"},  mem_wdata,       32'h0);
        check({tag, "_mem_be"},     32'(mem_be),     32'h0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready",  32'(req_ready),  32'(exp_ready));
            check("stall",      32'(stall),      32'(exp_stall));
            check("resp_valid", 32'(resp_valid), 32'(exp_rv));
            check("mem_req",    32'(mem_req),    32'(exp_req));
            check("resp_rdata", resp_rdata,      exp_rdata);
            check("resp_fault", 32'(resp_fault), 32'(exp_fault));
            if (exp_req) begin
                check("mem_addr", mem_addr,     exp_addr);
                check("mem_we",   32'(mem_we),  32'(exp_we));
                check("mem_be",   32'(mem_be),  32'(exp_be));
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; funct = LB; addr = '0; wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        set_idle_exp();
        exp_rdata = '0; exp_fault = 1'b0; exp_we = 1'b0;
        exp_addr = '0; exp_wdata = '0; exp_be = '0;
        repeat (2) @(posedge clk); #1;
        check_reset("por");
        rst = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;

        run(LW, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF);
        check("lw_rdata", resp_rdata, 32'hDEAD_BEEF);
        check("lw_be", 32'(snap_be), 32'hF);

        run(LB, 32'h103, 32'h0, 0, 0, 32'h80FF_FF7F);
        check("lb_rdata", resp_rdata, 32'hFFFF_FF80);
        run(LBU, 32'h103, 32'h0, 0, 0, 32'h80FF_FF7F);
        check("lbu_rdata", resp_rdata, 32'h0000_0080);

        // Reset while waiting for load data; the late rvalid must be dropped.
        chk_en = 1'b0;
        funct = LW; addr = 32'h400; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        check("rstwait_stall", 32'(stall), 32'h1);
        check("rstwait_req", 32'(mem_req), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55AA_55AA;
        check_reset("rst_mid");
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        check_reset("rst_after");
        exp_rdata = '0; exp_fault = 1'b0;
        set_idle_exp();
        chk_en = 1'b1;

        run(SH, 32'h202, 32'h1234_ABCD, 0, 0, 32'h0);
        check("sh_addr", snap_addr, 32'h200);
        check("sh_wdata", snap_wdata, 32'hABCD_ABCD);
        check("sh_be", 32'(snap_be), 32'hC);
        check("sh_we", 32'(snap_we), 32'h1);
        check("sh_req_cycles", 32'(req_count), 32'h1);

        run(SB, 32'h201, 32'h0000_00A5, 2, 0, 32'h0);
        check("sb_wdata", snap_wdata, 32'hA5A5_A5A5);
        check("sb_be", 32'(snap_be), 32'h2);
        run(SW, 32'h300, 32'hCAFE_F00D, 1, 0, 32'h0);
        run(LH, 32'h102, 32'h0, 1, 1, 32'h8001_7FFF);
        check("lh_rvalid_at_limit", resp_rdata, 32'hFFFF_8001);
        run(LHU, 32'h100, 32'h0, 0, 0, 32'h8001_7FFF);
        check("lhu_rdata", resp_rdata, 32'h0000_7FFF);

        run(LW, 32'h101, 32'h0, 0, 0, 32'h1122_3344);
        check("lw101_fault", 32'(resp_fault), TRAP ? 32'h1 : 32'h0);
        check("lw101_rdata", resp_rdata, TRAP ? 32'h0 : 32'h1122_3344);
        check("lw101_req_cycles", 32'(req_count), TRAP ? 32'h0 : 32'h1);
        run(LH, 32'h103, 32'h0, 0, 0, 32'hBEEF_1234);
        run(SB, 32'h333, 32'hFFFF_FF5A, 0, 0, 32'h0);
        check("sb3_be", 32'(snap_be), 32'h8);

        run(SW, 32'h310, 32'h1, 100, 0, 32'h0);
        check("tmo_req_cycles", 32'(req_count), 32'h4);
        check("tmo_fault", 32'(resp_fault), 32'h1);
        check("tmo_rdata", resp_rdata, 32'h0);
        run(LW, 32'h320, 32'h0, 0, 3, 32'h77);
        check("tmo_load_fault", 32'(resp_fault), 32'h1);
        run(LW, 32'h324, 32'h0, 0, 0, 32'h0000_0077);
        check("after_tmo_fault", 32'(resp_fault), 32'h0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store stage directly downstream of the ALU. It takes the ALU result as the effective address, plus rs2 as store data, and runs one data-bus transaction per request. It handles byte-lane steering, byte enables, load sign/zero extension, misalignment and bus-timeout faults, and holds the core stalled until the access completes. The response feeds the register-file writeback mux.

## Interface
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before a fault is forced; 0 disables the timeout.

- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core presents a memory op this cycle
- req_ready  out  1  unit can accept a request (IDLE only)
- funct  in  LSUFuncts::Type  LB/LH/LW/LBU/LHU/SB/SH/SW
- addr  in  RV32Consts::IntReg  effective address (ALU result)
- wdata  in  RV32Consts::IntReg  store data (rs2)
- stall  out  1  high whenever state != IDLE
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  RV32Consts::IntReg  extended load data; 0 for stores and faults
- resp_fault  out  1  misaligned or timed-out access, valid with resp_valid
- mem_req  out  1  bus request
- mem_we  out  1  1 = store
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_gnt  in  1  bus accepted the request this cycle
- mem_rvalid  in  1  load data valid, no earlier than the cycle after mem_gnt
- mem_rdata  in  32  load word

## Operation
- FSM states and transitions:
  - IDLE: on req_valid, latch funct, addr and wdata. Go to REQ, or to DONE with fault if the access is misaligned (see Configuration).
  - REQ: mem_req=1. On mem_gnt, stores go to DONE and loads go to WAIT.
  - WAIT: on mem_rvalid, capture mem_rdata and go to DONE.
  - DONE: resp_valid=1 for one cycle, then return to IDLE.
- Store steering:
  - SB: mem_wdata = 4×wdata[7:0]; mem_be = 1<<addr[1:0].
  - SH: mem_wdata = 2×wdata[15:0]; mem_be = 4'b0011 when addr[1]=0, 4'b1100 when addr[1]=1.
  - SW: mem_wdata = wdata; mem_be = 4'b1111.
- Load extraction:
  - Byte and halfword lanes are selected by the latched addr[1:0].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
  - For loads, mem_be=4'b1111 and mem_we=0.
- Misalignment:
  - Halfword ops with addr[0]=1.
  - Word ops with addr[1:0]≠0.
  - Byte ops are never misaligned.
- Timeout:
  - A counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT (TIMEOUT>0), go to DONE with resp_fault=1 and drop mem_req.
- resp_rdata and resp_fault are registered and hold their values until the next DONE.

## Timing
- Reset values:
  - State = IDLE; req_ready=1; stall=0.
  - resp_valid=0, resp_rdata=0, resp_fault=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
- Latency is counted from the accept cycle (cycle 0):
  - Store with immediate grant: mem_req in cycle 1, resp_valid in cycle 2.
  - Load with grant in cycle 1 and rvalid in cycle 2: resp_valid in cycle 3.
  - Misalignment fault: resp_valid in cycle 1, with no mem_req.
- Bus rules while mem_req=1:
  - mem_addr, mem_we, mem_wdata and mem_be are stable until mem_gnt.
  - mem_req deasserts in the cycle after mem_gnt.
- mem_gnt or mem_rvalid outside REQ or WAIT respectively is ignored.
- If mem_rvalid arrives in the same cycle the timeout fires, rvalid wins and no fault is raised.
- Reset mid-transaction: everything returns to reset values in the next cycle. The outstanding transaction is abandoned and a late mem_rvalid in IDLE is ignored.
- No new request is accepted in DONE; req_ready rises in the cycle after DONE.

## Configuration
- LSU_MISALIGN_TRAP_EN
  - Defined: misaligned accesses produce a fault and no bus traffic.
  - Undefined: the misalignment check is removed. The address is aligned down (halfword: addr[0] forced 0; word: addr[1:0] forced 0) and the access proceeds normally with resp_fault=0.
- Timeout faults are unaffected by this macro.

## Structure
- New package LSUFuncts, in the same style as ALUFuncts, holds:
  - typedef enum Type for the eight ops;
  - helper functions is_store, is_unsigned and access size (byte, half, word).
- Use RV32Consts::IntReg and XLEN for the data widths.
- One sub-module, lsu_lane_align: combinational store replication, byte-enable generation and load extraction/extension.
- The FSM and timeout counter live in the top module.

## Test plan
- LW at addr 0x100, grant in cycle 1, rvalid in cycle 2 with mem_rdata 0xDEADBEEF -> resp_rdata 0xDEADBEEF at cycle 3, mem_be 4'b1111.
- LB at 0x103 with mem_rdata 0x80FF_FF7F -> resp_rdata 0xFFFFFF80. LBU at the same address -> resp_rdata 0x00000080.
- SH at 0x202 with wdata 0x1234ABCD -> mem_addr 0x200, mem_wdata 0xABCDABCD, mem_be 4'b1100, mem_we=1; resp_valid one cycle after grant.
- LW at 0x101:
  - With LSU_MISALIGN_TRAP_EN: resp_fault=1 in cycle 1, mem_req never asserted.
  - Without it: a bus read at 0x100.
- TIMEOUT=4 and mem_gnt held low -> mem_req high for 4 cycles, then resp_valid with resp_fault=1 and resp_rdata 0.
- rst pulsed in WAIT, then mem_rvalid the following cycle -> all outputs at reset values and no resp_valid.
